// File: rtl/beat_window_counter.sv
// beat_window_counter: counts debounced heartbeat edges over fixed windows of clk cycles
// and publishes the closed window's count with a one-cycle strobe.
module beat_window_counter #(
  parameter int unsigned WINDOW_CYCLES  = 1_500_000_000,
  parameter int unsigned REFRACT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pulse_in,
  output logic [5:0] sum,
  output logic       sum_valid,
  output logic       saturated
);
  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam int RW = $clog2(REFRACT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(REFRACT_CYCLES - 1);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, prev_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] refr_q, refr_d;
  logic [5:0] sum_q, sum_d;
  logic sat_q, sat_d, vld_q, vld_d;
  logic beat, term;
  assign beat = s2_q && !prev_q && refr_q == '0 && state_q == COUNT;
  assign term = timer_q == T_LAST;
  // closing count includes a beat accepted in the terminal cycle; holds at 64
  assign cnt_inc = (beat && cnt_q != 7'd64) ? cnt_q + 7'd1 : cnt_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    refr_d  = refr_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    vld_d   = 1'b0;
    if (state_q == IDLE || !enable) begin
      state_d = enable ? COUNT : IDLE;
      timer_d = '0;
      cnt_d   = '0;
      refr_d  = '0;
    end else begin
      timer_d = term ? '0 : timer_q + 1'b1;
      cnt_d   = term ? '0 : cnt_inc;
      refr_d  = beat ? R_LOAD : (refr_q != '0 ? refr_q - 1'b1 : refr_q);
      sum_d   = term ? (cnt_inc[6] ? 6'd63 : cnt_inc[5:0]) : sum_q;
      sat_d   = term ? cnt_inc[6] : sat_q;
      vld_d   = term;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      refr_q  <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      s1_q    <= pulse_in;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      refr_q  <= refr_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end
  assign sum       = sum_q;
  assign sum_valid = vld_q;
  assign saturated = sat_q;
endmodule

// File: tb/tb_beat_window_counter.sv
// tb_beat_window_counter: scoreboard bench; u0 uses a 100-cycle window with 5-cycle refractory,
// u1 a 200-cycle window with 1-cycle refractory for saturation.
module tb_beat_window_counter;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic en0 = 1'b0, en1 = 1'b0, p0 = 1'b0, p1 = 1'b0;
  logic [5:0] sum0, sum1;
  logic sv0, sv1, sat0, sat1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {int s; int sat; int cyc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  beat_window_counter #(.WINDOW_CYCLES(100), .REFRACT_CYCLES(5)) u0 (
    .clk(clk), .rst(rst0), .enable(en0), .pulse_in(p0),
    .sum(sum0), .sum_valid(sv0), .saturated(sat0));
  beat_window_counter #(.WINDOW_CYCLES(200), .REFRACT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .pulse_in(p1),
    .sum(sum1), .sum_valid(sv1), .saturated(sat1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse0(input int n);
    at(n); p0 = 1'b1; at(n + 1); p0 = 1'b0;
  endtask

  task automatic pulse1(input int n);
    at(n); p1 = 1'b1; at(n + 1); p1 = 1'b0;
  endtask

  // edges every gap cycles; an edge is taken once r cycles have passed since the last taken one
  function automatic int ref_beats(input int n, input int gap, input int r);
    int last = -1000;
    int c = 0;
    for (int i = 0; i < n; i++)
      if (i * gap - last >= r) begin c++; last = i * gap; end
    return c;
  endfunction

  function automatic exp_t mk(input int s, input int sat, input int c);
    exp_t e;
    e.s = s; e.sat = sat; e.cyc = c;
    return e;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sv0) begin
      if (q0.size() == 0) chk("u0_unexpected_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("u0_valid_cycle", cyc, e.cyc);
        chk("u0_sum", int'(sum0), e.s);
        chk("u0_saturated", int'(sat0), e.sat);
      end
    end
    if (sv1) begin
      if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_valid_cycle", cyc, e.cyc);
        chk("u1_sum", int'(sum1), e.s);
        chk("u1_saturated", int'(sat1), e.sat);
      end
    end
  end

  initial begin
    int r;
    at(1);
    chk("u0_reset_sum", int'(sum0), 0);
    chk("u0_reset_valid", int'(sv0), 0);
    chk("u0_reset_sat", int'(sat0), 0);
    chk("u1_reset_sum", int'(sum1), 0);
    at(2);
    rst0 = 1'b0;
    rst1 = 1'b0;
    fork
      begin
        r = ref_beats(10, 2, 5);
        q0.push_back(mk(7, 0, 111));
        q0.push_back(mk(r, 0, 211));
        q0.push_back(mk(2, 0, 311));
        q0.push_back(mk(1, 0, 411));
        q0.push_back(mk(3, 0, 581));
        q0.push_back(mk(1, 0, 731));
        at(10); en0 = 1'b1;
        for (int i = 0; i < 7; i++) pulse0(20 + 10 * i);
        for (int i = 0; i < 10; i++) pulse0(120 + 2 * i);
        pulse0(250);
        pulse0(308);
        pulse0(310);
        pulse0(350);
        pulse0(420);
        at(461); en0 = 1'b0;
        at(470);
        chk("u0_abort_sum_hold", int'(sum0), 1);
        chk("u0_abort_sat_hold", int'(sat0), 0);
        at(480); en0 = 1'b1;
        pulse0(500);
        pulse0(510);
        pulse0(520);
        pulse0(600);
        at(630);
        #2 rst0 = 1'b1;
        #1;
        chk("u0_async_rst_sum", int'(sum0), 0);
        chk("u0_async_rst_valid", int'(sv0), 0);
        chk("u0_async_rst_sat", int'(sat0), 0);
        #1 rst0 = 1'b0;
        pulse0(650);
        at(735); en0 = 1'b0;
      end
      begin
        r = ref_beats(70, 2, 1);
        q1.push_back(mk(r > 63 ? 63 : r, r > 63 ? 1 : 0, 206));
        q1.push_back(mk(3, 0, 406));
        at(5); en1 = 1'b1;
        for (int i = 0; i < 70; i++) pulse1(10 + 2 * i);
        pulse1(250);
        pulse1(260);
        pulse1(270);
        at(410); en1 = 1'b0;
      end
    join
    at(745);
    chk("u0_all_windows_seen", q0.size(), 0);
    chk("u1_all_windows_seen", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/beat_window_counter.md
BEAT_WINDOW_COUNTER -- requirements
Module: beat_window_counter

Interface
REQ-001 The block SHALL provide parameter WINDOW_CYCLES, default 1_500_000_000, giving the counting window length in clk cycles (15 s at 100 MHz).
REQ-002 The block SHALL provide parameter REFRACT_CYCLES, default 25_000_000, giving the post-beat ignore period in clk cycles (250 ms at 100 MHz).
REQ-003 The block SHALL provide port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 The block SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL provide port enable, input, 1 bit: 1 = count windows, 0 = idle.
REQ-006 The block SHALL provide port pulse_in, input, 1 bit: raw heartbeat sensor level, asynchronous to clk.
REQ-007 The block SHALL provide port sum, output, 6 bits: beat count of the last completed window, feeding the downstream BPM converter.
REQ-008 The block SHALL provide port sum_valid, output, 1 bit: one-cycle strobe when sum updates.
REQ-009 The block SHALL provide port saturated, output, 1 bit: the last completed window exceeded 63 beats.

Function
REQ-010 pulse_in SHALL pass through a 2-flop synchronizer; a third flop holds the previous synced value for edge detection.
REQ-011 A rising edge SHALL be detected when synced = 1 and previous = 0, i.e. 3 clk cycles after pulse_in rises.
REQ-012 A rising edge SHALL be accepted as a beat only if the refractory counter is 0 and the state is COUNT; otherwise it is discarded.
REQ-013 On an accepted beat, the refractory counter SHALL load REFRACT_CYCLES-1 and decrement by 1 per cycle to 0; edges while it is non-zero are ignored.
REQ-014 The FSM SHALL have states IDLE and COUNT.
REQ-015 In IDLE with enable = 1, the FSM SHALL go to COUNT next cycle with window timer = 0, beat count = 0, refractory = 0.
REQ-016 In COUNT with enable = 0, the FSM SHALL go to IDLE next cycle, discard the partial window, and clear timer, count and refractory; sum and saturated hold and no sum_valid fires.
REQ-017 In COUNT the window timer SHALL increment every cycle from 0 to WINDOW_CYCLES-1, then wrap to 0.
REQ-018 At timer = WINDOW_CYCLES-1 (terminal cycle), the next cycle SHALL load sum with the closing beat count, including a beat accepted in the terminal cycle; the same edge loads saturated and pulses sum_valid high for exactly 1 cycle.
REQ-019 After the terminal cycle the beat count SHALL restart at 0; a beat in the terminal cycle belongs only to the closing window.
REQ-020 The beat count SHALL be 7 bits internally and saturate at 64; sum = min(count, 63) and saturated = (count > 63).
REQ-021 The refractory counter SHALL NOT be cleared at window wrap, so a beat near the boundary still suppresses the beats that follow in the new window.
REQ-022 The window timer width SHALL be $clog2(WINDOW_CYCLES) and the refractory counter width $clog2(REFRACT_CYCLES+1).
REQ-023 sum, sum_valid and saturated SHALL be registered outputs with no combinational path from any input.

Reset
REQ-024 Asserting rst SHALL immediately force sum = 0, sum_valid = 0, saturated = 0, state = IDLE, and clear timer, beat count, refractory counter and synchronizer flops.
REQ-025 Reset asserted mid-window SHALL discard the window with no sum_valid; after rst falls, counting resumes per REQ-015 only when enable = 1.

Verification
REQ-026 Use WINDOW_CYCLES = 100, REFRACT_CYCLES = 5 for all scenarios.
REQ-027 Basic window: enable = 1; 7 clean pulses 10 cycles apart -> at window end sum = 7, saturated = 0, sum_valid high for 1 cycle.
REQ-028 Refractory: pulses 2 cycles apart -> only every third edge is counted, and the sum matches a reference model.
REQ-029 Boundary: edge accepted in the terminal cycle -> counted in the closing window; a new-window edge 2 cycles later is ignored (refractory).
REQ-030 Saturation: with REFRACT_CYCLES = 1 and WINDOW_CYCLES = 200, 70 accepted beats -> sum = 63, saturated = 1; the next window with 3 beats -> sum = 3, saturated = 0.
REQ-031 Abort: enable drops at cycle 50 -> no sum_valid and sum holds its previous value; re-enable -> a full 100-cycle window follows.
REQ-032 Async reset: rst pulsed for less than 1 cycle mid-window -> all outputs 0 at once and no spurious sum_valid afterwards.
